// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor front end.
// The BP_GSHARE_EN macro selects the gshare hash; without it the hash is bimodal.
package bp_pkg;

  localparam int unsigned BP_IDX_W = 4;
  localparam int unsigned BP_PC_W  = 32;

  typedef logic [BP_IDX_W-1:0] bp_idx_t;

  // PC/history hash for the default widths; word-aligned PC bits select the entry
  function automatic bp_idx_t bp_hash(input logic [BP_PC_W-1:0] pc, input bp_idx_t hist);
`ifdef BP_GSHARE_EN
    return pc[BP_IDX_W+1:2] ^ hist;
`else
    return pc[BP_IDX_W+1:2] | (hist & '0);
`endif
  endfunction

endpackage

// File: rtl/branch_index_gen_if.sv
// Lookup / resolve / update bundle between the fetch front end and branch_index_gen.
interface branch_index_gen_if #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned IDX_W = 4
);
  logic             pc_valid;
  logic [PC_W-1:0]  pc;
  logic             pc_ready;
  logic [IDX_W-1:0] index;
  logic             index_valid;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             update_valid;
  logic [IDX_W-1:0] update_index;
  logic             update_taken;
  logic [IDX_W-1:0] ghr;
  logic             full;
  logic             empty;
  logic             resolve_err;

  modport master (
    output pc_valid, pc, resolve_valid, resolve_taken,
    input  pc_ready, index, index_valid, update_valid, update_index,
           update_taken, ghr, full, empty, resolve_err
  );

  modport slave (
    input  pc_valid, pc, resolve_valid, resolve_taken,
    output pc_ready, index, index_valid, update_valid, update_index,
           update_taken, ghr, full, empty, resolve_err
  );
endinterface

// File: rtl/bp_index_fifo.sv
// In-flight index FIFO: synchronous, no push-to-pop bypass, async active-high reset.
// Caller guarantees push only when not full and pop only when not empty.
module bp_index_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  // Storage write; contents need no reset since reads are gated by count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of two)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/branch_index_gen.sv
// Branch predictor index generator: hashes PC (and GHR when BP_GSHARE_EN is
// defined) into a table index, tracks in-flight indices, emits updates on resolve.
module branch_index_gen
  import bp_pkg::*;
#(
  parameter int unsigned PC_W  = BP_PC_W,
  parameter int unsigned IDX_W = BP_IDX_W,
  parameter int unsigned DEPTH = 4
) (
  input logic              clk,
  input logic              reset,
  branch_index_gen_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] h;
  logic [IDX_W-1:0] ghr_q;
  logic [IDX_W-1:0] index_q;
  logic [IDX_W-1:0] update_index_q;
  logic             index_valid_q;
  logic             update_valid_q;
  logic             update_taken_q;
  logic             resolve_err_q;
  logic             full;
  logic             empty;
  logic             accept;
  logic             do_pop;
  logic             unused_pc_bits;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign accept = bus.pc_valid && !full;
  assign do_pop = bus.resolve_valid && !empty;

  assign unused_pc_bits = ^{bus.pc[PC_W-1:IDX_W+2], bus.pc[1:0]};

`ifdef BP_GSHARE_EN
  // Non-speculative history: shifts only when a branch actually resolves
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       ghr_q <= '0;
    else if (do_pop) ghr_q <= {ghr_q[IDX_W-2:0], bus.resolve_taken};
  end
  assign h = bus.pc[IDX_W+1:2] ^ ghr_q;
`else
  assign ghr_q = '0;
  assign h     = bus.pc[IDX_W+1:2];
`endif

  bp_index_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (do_pop),
    .din   (h),
    .head  (head),
    .count (count)
  );

  // Registered lookup result; index holds when no lookup is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index_q       <= '0;
      index_valid_q <= 1'b0;
    end else begin
      index_valid_q <= accept;
      if (accept) index_q <= h;
    end
  end

  // Update pulse on resolve, plus sticky error for resolves with nothing in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      update_valid_q <= 1'b0;
      update_index_q <= '0;
      update_taken_q <= 1'b0;
      resolve_err_q  <= 1'b0;
    end else begin
      update_valid_q <= do_pop;
      if (do_pop) begin
        update_index_q <= head;
        update_taken_q <= bus.resolve_taken;
      end
      if (bus.resolve_valid && empty) resolve_err_q <= 1'b1;
    end
  end

  assign bus.pc_ready     = !full;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.index        = index_q;
  assign bus.index_valid  = index_valid_q;
  assign bus.update_valid = update_valid_q;
  assign bus.update_index = update_index_q;
  assign bus.update_taken = update_taken_q;
  assign bus.ghr          = ghr_q;
  assign bus.resolve_err  = resolve_err_q;
endmodule

// File: doc/branch_index_gen.md
# branch_index_gen

Upstream front end of the branch predictor: hashes each fetched branch PC with a global history register (GHR) into the 4-bit table index that `predictor_top` consumes, and holds each issued index in an in-flight FIFO until the branch resolves. On resolution it pops the oldest entry and emits an update (index + outcome) for the predictor, then shifts the outcome into the GHR. All state is non-speculative: the GHR changes only at resolution.

## Interface
Parameters:
- `PC_W`, 32, branch PC width
- `IDX_W`, 4, predictor index width; also the GHR width
- `DEPTH`, 4, in-flight FIFO entries; must be a power of two and at least 2

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `pc_valid`  in  1  lookup request
- `pc`  in  PC_W  branch PC
- `pc_ready`  out  1  `!full`; a lookup is accepted when `pc_valid && pc_ready`
- `index`  out  IDX_W  registered lookup index for the predictor
- `index_valid`  out  1  `index` is valid this cycle
- `resolve_valid`  in  1  the oldest in-flight branch resolves
- `resolve_taken`  in  1  actual outcome (1 = taken)
- `update_valid`  out  1  update pulse to the predictor
- `update_index`  out  IDX_W  index of the resolved branch
- `update_taken`  out  1  outcome of the resolved branch
- `ghr`  out  IDX_W  current history, newest outcome in bit 0
- `full`, `empty`  out  1  FIFO status
- `resolve_err`  out  1  sticky flag: a resolve arrived while the FIFO was empty

## Operation
- Hash: `h = pc[IDX_W+1:2] ^ ghr`, using the registered GHR value from the cycle of acceptance.
- Accepted lookup: on the same edge, `index <= h`, `index_valid <= 1`, and `h` is pushed at the FIFO tail. Otherwise `index_valid <= 0` and `index` holds its value.
- Resolve with FIFO not empty, on the same edge:
  - pop the head
  - `update_index <= head`, `update_taken <= resolve_taken`, `update_valid <= 1`
  - `ghr <= {ghr[IDX_W-2:0], resolve_taken}`
- Resolve with FIFO empty: no pop, no GHR change, `update_valid <= 0`, `resolve_err <= 1`. The flag stays set until reset.
- Simultaneous accept and resolve:
  - both happen, and `count` is unchanged
  - the lookup hashes with the pre-update GHR
  - when the FIFO is empty, the resolve is still an error (a push does not bypass to the pop)
- When full, `pc_ready = 0`. A resolve in that cycle still pops; `pc_ready` rises the next cycle.
- Pointers wrap modulo `DEPTH`. `count` runs 0..DEPTH and is `$clog2(DEPTH+1)` bits wide. `full = (count==DEPTH)`, `empty = (count==0)`.
- Reset, including mid-operation, flushes the FIFO; in-flight entries are discarded.

## Timing
- Reset values: `index=0`, `index_valid=0`, `update_valid=0`, `update_index=0`, `update_taken=0`, `ghr=0`, `resolve_err=0`, `full=0`, `empty=1`, `pc_ready=1`.
- Lookup latency: 1 cycle from accept to `index_valid`.
- Update latency: 1 cycle from resolve to `update_valid`. The new `ghr` is visible from the same edge.
- `pc_ready`, `full` and `empty` are combinational from registered `count`; there is no combinational path from inputs.
- Throughput: 1 lookup and 1 resolve per cycle.

## Configuration
- `BP_GSHARE_EN` defined: the gshare hash and GHR are as above.
- `BP_GSHARE_EN` undefined: bimodal mode.
  - `h = pc[IDX_W+1:2]`
  - the GHR register is not built; the `ghr` output is tied to 0
  - FIFO, update path and `resolve_err` are unchanged

## Structure
- `bp_pkg` holds:
  - constants `BP_IDX_W=4` and `BP_PC_W=32`
  - `typedef logic [BP_IDX_W-1:0] bp_idx_t`
  - a `bp_hash` function for the PC/GHR hash (it honours `BP_GSHARE_EN`)
- Sub-module `bp_index_fifo`: parameterised synchronous FIFO with push, pop, head and count. It has no bypass and uses the same asynchronous reset.

## Test plan
- Reset, then lookup `pc=0x0000_0014`, `ghr=0` -> next cycle `index_valid=1`, `index=4'h5`.
- Resolve taken ×3, then lookup `pc=0x14` -> `ghr=4'b0111`, `index=4'h2` (bimodal build: `4'h5`).
- Issue 4 lookups without resolving:
  - `full=1`, `pc_ready=0`, a 5th `pc_valid` is ignored
  - one resolve -> `update_index` equals the first-issued index
  - `pc_ready=1` the next cycle
- Resolve on an empty FIFO -> `update_valid=0`, `ghr` unchanged, `resolve_err=1` and it stays set.
- Accept and resolve in the same cycle with `count=2`:
  - `count` stays 2
  - the new index uses the old GHR
  - the update reports the head entry
- Assert `reset` mid-stream with `count=3` -> `empty=1`, `ghr=0`, all outputs at reset values asynchronously. The next resolve sets `resolve_err`.
